apb_requester: RTL

//  APB3 requester (master). Turns single-beat read/write commands from a valid/ready port

---
 rtl/apb_req_pkg.sv | 32 +++
 rtl/apb_req_timer.sv | 36 +++
 rtl/apb_requester.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_req_pkg.sv
// Shared types for the APB requester.
// Holds the FSM state enum, the command/response record layouts at the default
// 32-bit bus width, and a small helper used to derive PSEL from the FSM state.
package apb_req_pkg;

  localparam int APB_REQ_ADDR_W = 32;
  localparam int APB_REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_req_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_REQ_ADDR_W-1:0] addr;
    logic [APB_REQ_DATA_W-1:0] wdata;
  } apb_req_cmd_t;

  typedef struct packed {
    logic [APB_REQ_DATA_W-1:0] rdata;
    logic                      err;
    logic                      tmo;
  } apb_req_rsp_t;

  // The bus is selected in every state except IDLE.
  function automatic logic apb_req_busy(input apb_req_state_e s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/apb_req_timer.sv
// ACCESS-phase watchdog for the APB requester.
// Ports:
//   PCLK, PRESET  clock and asynchronous active-high reset
//   load          clear the count (asserted in SETUP)
//   count         advance the count (ACCESS cycle with PREADY low)
//   expired       high during the TIMEOUT_CYCLES-th ACCESS cycle; if PREADY is
//                 still low in that cycle the transfer is aborted at its end
module apb_req_timer #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds the number of stalled ACCESS cycles already completed, so the
  // current cycle is the last permitted one when it equals TIMEOUT_CYCLES-1.
  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_requester.sv
// APB3 requester: turns single-beat read/write commands on a valid/ready port
// into APB transfers and returns each result through a one-entry response
// register on a valid/ready port.
// Optional feature macro: APB_REQ_TIMEOUT_EN (ACCESS-phase timeout/abort).
// Ports:
//   PCLK, PRESET                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_write/cmd_addr/cmd_wdata      command payload
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata/rsp_err/rsp_tmo         response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request (all registered)
//   PRDATA/PREADY/PSLVERR             APB completion from the completer
module apb_requester
  import apb_req_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_requester: TIMEOUT_CYCLES must be >= 1");
  end

  apb_req_state_e state, state_nxt;
  logic           accept;
  logic           done;
  logic           abort;

  // A new command may enter only when the response register is empty or is
  // being drained this very cycle; the next completion is at least two
  // cycles away, so it can never collide with the pop.
  assign cmd_ready = !PRESET && (state == IDLE) && (!rsp_valid || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign done      = (state == ACCESS) && PREADY;

`ifdef APB_REQ_TIMEOUT_EN
  logic tmr_expired;

  apb_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .load    (state == SETUP),
    .count   ((state == ACCESS) && !PREADY),
    .expired (tmr_expired)
  );

  // PREADY in the expiry cycle wins: only a still-stalled transfer aborts.
  assign abort = (state == ACCESS) && !PREADY && tmr_expired;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // PSEL/PENABLE are registered from the next state so they follow the FSM
  // exactly, and drop asynchronously with PRESET.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      state   <= state_nxt;
      PSEL    <= apb_req_busy(state_nxt);
      PENABLE <= (state_nxt == ACCESS);
    end
  end

  // Request payload is captured on accept and then held through SETUP,
  // ACCESS and the following IDLE period.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // One-entry response register. Completion only occurs with the register
  // empty, so load and pop never coincide.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (done) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= PWRITE ? '0 : PRDATA;
      rsp_err   <= PSLVERR;
    end else if (abort) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef APB_REQ_TIMEOUT_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_tmo <= 1'b0;
    end else if (done) begin
      rsp_tmo <= 1'b0;
    end else if (abort) begin
      rsp_tmo <= 1'b1;
    end
  end
`else
  assign rsp_tmo = 1'b0;
`endif

endmodule
